// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button front-end.
package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_HELD,
    BTN_REPEAT
  } btn_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, debouncer, press/auto-repeat FSM.
// Events are suppressed, and the repeat timer held at 0, while inhibit is high.
module btn_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic inhibit,
  output logic level,
  output logic press_evt
);

  localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = cnt_width(TMAX);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = (REPEAT_DELAY == 0) ? '0 : TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] db_cnt;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          raw_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= ~stable;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BTN_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    raw_evt   = 1'b0;
    case (state)
      BTN_IDLE: begin
        timer_nxt = '0;
        if (stable) begin
          raw_evt   = 1'b1;
          state_nxt = BTN_HELD;
        end
      end
      BTN_HELD: begin
        if (!stable) begin
          state_nxt = BTN_IDLE;
          timer_nxt = '0;
        end else if (inhibit) begin
          timer_nxt = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (timer == RD_LAST) begin
            raw_evt   = 1'b1;
            timer_nxt = '0;
            state_nxt = BTN_REPEAT;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
      end
      BTN_REPEAT: begin
        if (!stable) begin
          state_nxt = BTN_IDLE;
          timer_nxt = '0;
        end else if (inhibit) begin
          timer_nxt = '0;
        end else if (timer == RR_LAST) begin
          raw_evt   = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = BTN_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  assign press_evt = raw_evt & ~inhibit;
  assign level     = stable;

endmodule

// File: rtl/button_pulse_gen.sv
// East/west button front-end: two debounced channels that inhibit each other,
// so the registered press pulses can never be high together.
module button_pulse_gen
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic east_raw,
  input  logic west_raw,
  output logic east_pulse,
  output logic west_pulse,
  output logic east_level,
  output logic west_level
);

  logic east_evt;
  logic west_evt;

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_east (
    .clk      (clk),
    .reset    (reset),
    .raw      (east_raw),
    .inhibit  (west_level),
    .level    (east_level),
    .press_evt(east_evt)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_west (
    .clk      (clk),
    .reset    (reset),
    .raw      (west_raw),
    .inhibit  (east_level),
    .level    (west_level),
    .press_evt(west_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      east_pulse <= 1'b0;
      west_pulse <= 1'b0;
    end else begin
      east_pulse <= east_evt;
      west_pulse <= west_evt;
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench for button_pulse_gen: a reference model predicts pulse cycles
// and levels; a monitor compares them against the DUT each cycle.
module tb_button_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic reset;
  logic east_raw;
  logic west_raw;
  logic east_pulse;
  logic west_pulse;
  logic east_level;
  logic west_level;

  always #5 clk = ~clk;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .east_raw  (east_raw),
    .west_raw  (west_raw),
    .east_pulse(east_pulse),
    .west_pulse(west_pulse),
    .east_level(east_level),
    .west_level(west_level)
  );

  typedef struct {
    int cyc;
    bit ch;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference state, index 0 = east, 1 = west.
  bit m_s1[2], m_s2[2], m_stable[2], m_active[2];
  int m_run[2], m_elapsed[2], m_interval[2];

  // Window statistics for directed scenarios.
  int  e_cnt, w_cnt, e_first, e_last, w_first;
  bit  prev_e, prev_w;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Behavioural model evaluated at each clock edge from the pre-edge state.
  task automatic model_step();
    bit raw_in[2];
    bit old_stable[2];
    bit ev;
    cyc++;
    raw_in[0] = east_raw;
    raw_in[1] = west_raw;
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_stable[ch] = 0; m_active[ch] = 0;
        m_run[ch] = 0; m_elapsed[ch] = 0; m_interval[ch] = 0;
      end
    end else begin
      old_stable = m_stable;
      for (int ch = 0; ch < 2; ch++) begin
        ev = 0;
        if (!old_stable[ch]) begin
          m_active[ch] = 0;
        end else if (!m_active[ch]) begin
          m_active[ch]   = 1;
          m_elapsed[ch]  = 0;
          m_interval[ch] = RD;
          ev = !old_stable[1-ch];
        end else if (old_stable[1-ch]) begin
          m_elapsed[ch] = 0;
        end else if (m_interval[ch] != 0) begin
          if (m_elapsed[ch] == m_interval[ch] - 1) begin
            ev = 1;
            m_elapsed[ch]  = 0;
            m_interval[ch] = RR;
          end else begin
            m_elapsed[ch]++;
          end
        end
        if (ev) sb.push_back('{cyc: cyc, ch: ch[0]});
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (m_s2[ch] == m_stable[ch]) m_run[ch] = 0;
        else if (m_run[ch] + 1 >= DB) begin
          m_stable[ch] = !m_stable[ch];
          m_run[ch] = 0;
        end else m_run[ch]++;
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = raw_in[ch];
      end
    end
  endtask

  task automatic monitor_step();
    bit ch;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_pulse: ch=%0d got none, expected pulse at cycle %0d", sb[0].ch, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (east_pulse || west_pulse) begin
      ch = west_pulse && !east_pulse;
      checks++;
      if (sb.size() == 0 || sb[0].cyc != cyc || sb[0].ch != ch) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got ch=%0d at cycle %0d, expected %s", ch, cyc,
                 (sb.size() == 0) ? "nothing" : $sformatf("ch=%0d at cycle %0d", sb[0].ch, sb[0].cyc));
      end else begin
        void'(sb.pop_front());
      end
    end
    check_output("east_level", int'(east_level), int'(m_stable[0]));
    check_output("west_level", int'(west_level), int'(m_stable[1]));
    check_output("pulse_exclusive", int'(east_pulse && west_pulse), 0);
    if (east_pulse) check_output("east_pulse_width", int'(prev_e), 0);
    if (west_pulse) check_output("west_pulse_width", int'(prev_w), 0);
    prev_e = east_pulse;
    prev_w = west_pulse;
    if (east_pulse) begin
      if (e_cnt == 0) e_first = cyc;
      e_last = cyc;
      e_cnt++;
    end
    if (west_pulse) begin
      if (w_cnt == 0) w_first = cyc;
      w_cnt++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    monitor_step();
  end

  task automatic mark_window();
    e_cnt = 0; w_cnt = 0; e_first = -1; e_last = -1; w_first = -1;
  endtask

  task automatic apply_stimulus(input bit e, input bit w, input int n);
    east_raw = e;
    west_raw = w;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t, t2, r, exp_cnt, exp_last, fall, e_hold, w_hold;
    reset = 1'b1;
    east_raw = 1'b0;
    west_raw = 1'b0;
    mark_window();
    repeat (3) @(negedge clk);
    check_output("reset_east_pulse", int'(east_pulse), 0);
    check_output("reset_west_pulse", int'(west_pulse), 0);
    check_output("reset_east_level", int'(east_level), 0);
    check_output("reset_west_level", int'(west_level), 0);
    reset = 1'b0;
    apply_stimulus(0, 0, 5);

    // Clean press: single pulse DB+3 cycles after the raw edge.
    mark_window();
    t = cyc;
    apply_stimulus(1, 0, 10);
    apply_stimulus(0, 0, 20);
    check_output("clean_east_count", e_cnt, 1);
    check_output("clean_east_cycle", e_first, t + DB + 3);
    check_output("clean_west_count", w_cnt, 0);

    // Bouncing west, then a settled press.
    mark_window();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 2);
      apply_stimulus(0, 0, 2);
    end
    t = cyc;
    apply_stimulus(0, 1, 15);
    apply_stimulus(0, 0, 15);
    check_output("bounce_west_count", w_cnt, 1);
    check_output("bounce_west_cycle", w_first, t + DB + 3);

    mark_window();
    apply_stimulus(0, 1, 3);
    apply_stimulus(0, 0, 15);
    check_output("glitch_west_count", w_cnt, 0);

    // Auto-repeat while held for 60 cycles.
    mark_window();
    t = cyc;
    apply_stimulus(1, 0, 60);
    apply_stimulus(0, 0, 30);
    fall = t + 60 + DB + 2;
    exp_cnt = 1;
    exp_last = t + DB + 3;
    for (int p = t + DB + 3 + RD; p <= fall; p += RR) begin
      exp_cnt++;
      exp_last = p;
    end
    check_output("repeat_count", e_cnt, exp_cnt);
    check_output("repeat_first", e_first, t + DB + 3);
    check_output("repeat_last", e_last, exp_last);

    // Simultaneous press: nothing until west releases.
    mark_window();
    apply_stimulus(1, 1, 40);
    check_output("simul_pulses", e_cnt + w_cnt, 0);
    mark_window();
    t2 = cyc;
    apply_stimulus(1, 0, 40);
    check_output("simul_resume_cycle", e_first, t2 + DB + 2 + RD);
    check_output("simul_west_count", w_cnt, 0);
    apply_stimulus(0, 0, 20);

    // Reset while east is auto-repeating.
    apply_stimulus(1, 0, 45);
    mark_window();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_output("midreset_pulses", e_cnt + w_cnt, 0);
    reset = 1'b0;
    r = cyc;
    apply_stimulus(1, 0, 20);
    check_output("midreset_count", e_cnt, 1);
    check_output("midreset_cycle", e_first, r + DB + 3);
    apply_stimulus(0, 0, 20);

    // Random raw activity with occasional resets.
    e_hold = 0;
    w_hold = 0;
    for (int i = 0; i < 10000; i++) begin
      if (e_hold == 0) begin
        east_raw = 1'($urandom_range(0, 1));
        e_hold = int'($urandom_range(1, 40));
      end else e_hold--;
      if (w_hold == 0) begin
        west_raw = 1'($urandom_range(0, 1));
        w_hold = int'($urandom_range(1, 40));
      end else w_hold--;
      reset = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    apply_stimulus(0, 0, 100);
    check_output("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
